regop_sequencer: RTL

- Command sequencer for a single 32-bit datapath register with E / FunSel[2:0] / I[15:0] controls.
- Takes one high-level command per handshake and expands it into a timed sequence of E/FunSel/I cycles, e.g. a full 32-bit load as four 8-bit shift-in cycles, or a multi-step increment.
- Sits between the control unit and the register.

---
 rtl/regop_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/regop_sequencer.sv
// Expands one high-level register command (CLR/INC/DEC/LOAD*) into a timed
// sequence of E/FunSel/I cycles for a 32-bit datapath register.
module regop_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_data,
    input  logic [CNT_W-1:0] req_count,
    input  logic             abort,
    output logic             reg_E,
    output logic [2:0]       reg_FunSel,
    output logic [15:0]      reg_I,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // state | meaning
    // IDLE  | waiting for a command; drives E=0, FunSel=000, I=0
    // EXEC  | one register step per cycle, cnt_q = steps left after this one
    typedef enum logic {IDLE, EXEC} state_t;

    localparam logic [2:0] OP_CLR    = 3'b000;
    localparam logic [2:0] OP_INC    = 3'b001;
    localparam logic [2:0] OP_DEC    = 3'b010;
    localparam logic [2:0] OP_LOAD16 = 3'b011;
    localparam logic [2:0] OP_SEXT16 = 3'b100;
    localparam logic [2:0] OP_LOAD32 = 3'b101;
    localparam logic [2:0] OP_LOAD8  = 3'b110;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [31:0]      data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             e_q, busy_q, done_q, err_q;
    logic [2:0]       funsel_q;
    logic [15:0]      i_q;

    logic [CNT_W-1:0] n_req;
    logic [2:0]       sel_op;
    logic [31:0]      sel_data;
    logic [CNT_W-1:0] sel_rem;
    logic [2:0]       funsel_d;
    logic [15:0]      i_d;
    logic [7:0]       byte_d;

    assign req_ready  = (state_q == IDLE) && !rst;
    assign reg_E      = e_q;
    assign reg_FunSel = funsel_q;
    assign reg_I      = i_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

    always_comb begin
        n_req = '0;
        case (req_op)
            OP_CLR, OP_LOAD16, OP_SEXT16, OP_LOAD8: n_req = CNT_W'(1);
            OP_INC, OP_DEC:                         n_req = req_count;
            OP_LOAD32:                              n_req = CNT_W'(4);
            default:                                n_req = '0;
        endcase
    end

    // The step about to be driven comes from the live request when accepting,
    // otherwise from the latched command; sel_rem is steps left after it.
    always_comb begin
        sel_op   = (state_q == IDLE) ? req_op   : op_q;
        sel_data = (state_q == IDLE) ? req_data : data_q;
        sel_rem  = (state_q == IDLE) ? n_req - CNT_W'(1) : cnt_q - CNT_W'(1);
        byte_d   = '0;
        case (sel_rem[1:0])
            2'd3:    byte_d = sel_data[31:24];
            2'd2:    byte_d = sel_data[23:16];
            2'd1:    byte_d = sel_data[15:8];
            default: byte_d = sel_data[7:0];
        endcase
        funsel_d = 3'b000;
        i_d      = '0;
        case (sel_op)
            OP_CLR:    funsel_d = 3'b011;
            OP_INC:    funsel_d = 3'b001;
            OP_DEC:    funsel_d = 3'b000;
            OP_LOAD16: begin funsel_d = 3'b010; i_d = sel_data[15:0]; end
            OP_SEXT16: begin funsel_d = 3'b111; i_d = sel_data[15:0]; end
            OP_LOAD32: begin funsel_d = 3'b110; i_d = {8'h00, byte_d}; end
            OP_LOAD8:  begin funsel_d = 3'b100; i_d = {8'h00, sel_data[7:0]}; end
            default:   begin funsel_d = 3'b000; i_d = '0; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            e_q      <= 1'b0;
            funsel_q <= '0;
            i_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            e_q      <= 1'b0;
            funsel_q <= '0;
            i_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q   <= req_op;
                        data_q <= req_data;
                        if (n_req == '0) begin
                            done_q <= 1'b1;
                            err_q  <= (req_op == 3'b111);
                        end else begin
                            state_q  <= EXEC;
                            cnt_q    <= n_req - CNT_W'(1);
                            e_q      <= 1'b1;
                            funsel_q <= funsel_d;
                            i_q      <= i_d;
                            busy_q   <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    // Abort only counts as an error if steps were actually cut off.
                    if (cnt_q == '0 || abort) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        err_q   <= (cnt_q != '0);
                        cnt_q   <= '0;
                    end else begin
                        cnt_q    <= cnt_q - CNT_W'(1);
                        e_q      <= 1'b1;
                        funsel_q <= funsel_d;
                        i_q      <= i_d;
                        busy_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
